// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU.
// One transaction is outstanding at a time. The LSU has priority, but a starvation limit lets a waiting fetch through.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_ack,
  input  logic                i_lsu_req,
  input  logic                i_lsu_wren,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_bmask,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_lsu_ack,
  output logic                o_mem_req,
  output logic                o_mem_wren,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_stall_if,
  output logic                o_stall_lsu
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t     state;
  logic       owner_lsu;
  logic       kill;
  logic [3:0] starve_cnt;

  logic ack_cycle;
  logic if_ok;
  logic grant_lsu;
  logic grant_if;

  // The ack cycle is never arbitrated, so a requester that is still dropping its request is not served twice.
  always_comb begin
    ack_cycle = o_if_ack | o_lsu_ack;
    if_ok     = i_if_req & ~i_flush;
    grant_lsu = i_lsu_req & ~(if_ok & (starve_cnt == STARVE_LIM));
    grant_if  = if_ok & ~grant_lsu;
  end

  assign o_stall_if  = i_if_req & ~o_if_ack & ~i_flush;
  assign o_stall_lsu = i_lsu_req & ~o_lsu_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      owner_lsu   <= 1'b0;
      kill        <= 1'b0;
      starve_cnt  <= '0;
      o_mem_req   <= 1'b0;
      o_mem_wren  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      o_if_ack    <= 1'b0;
      o_lsu_ack   <= 1'b0;
      o_if_rdata  <= '0;
      o_lsu_rdata <= '0;
    end else begin
      o_if_ack  <= 1'b0;
      o_lsu_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_if_req)
            starve_cnt <= '0;
          if (!ack_cycle && (grant_lsu || grant_if)) begin
            owner_lsu <= grant_lsu;
            o_mem_req <= 1'b1;
            state     <= S_REQ;
            if (grant_lsu) begin
              o_mem_wren  <= i_lsu_wren;
              o_mem_addr  <= i_lsu_addr;
              o_mem_wdata <= i_lsu_wdata;
              o_mem_bmask <= i_lsu_wren ? i_lsu_bmask : '1;
              if (i_if_req && (starve_cnt != STARVE_LIM))
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
              o_mem_wren  <= 1'b0;
              o_mem_addr  <= i_if_addr;
              o_mem_wdata <= '0;
              o_mem_bmask <= '1;
              starve_cnt  <= '0;
            end
          end
        end
        S_REQ: begin
          if (!owner_lsu && i_flush)
            kill <= 1'b1;
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!owner_lsu && i_flush)
            kill <= 1'b1;
          if (i_mem_rvalid) begin
            if (owner_lsu) begin
              o_lsu_rdata <= i_mem_rdata;
              o_lsu_ack   <= 1'b1;
            end else if (!(kill || i_flush)) begin
              o_if_rdata <= i_mem_rdata;
              o_if_ack   <= 1'b1;
            end
            kill  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It contains a behavioural memory with programmable grant and response delays.
// A queue-based scoreboard checks every ack in order.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_ack;
  logic        i_lsu_req;
  logic        i_lsu_wren;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_bmask;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_ack;
  logic        o_mem_req;
  logic        o_mem_wren;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_stall_if;
  logic        o_stall_lsu;

  initial forever #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_lsu_req(i_lsu_req), .i_lsu_wren(i_lsu_wren), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_bmask(i_lsu_bmask),
    .o_lsu_rdata(o_lsu_rdata), .o_lsu_ack(o_lsu_ack),
    .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_stall_if(o_stall_if), .o_stall_lsu(o_stall_lsu)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        lsu;
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input logic lsu, input logic chk, input logic [31:0] data);
    exp_t e;
    e.lsu = lsu; e.chk = chk; e.data = data;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every ack pops the oldest expectation
  initial forever begin
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      logic        ack;
      logic [31:0] rd;
      exp_t        e;
      ack = (s == 0) ? o_lsu_ack : o_if_ack;
      rd  = (s == 0) ? o_lsu_rdata : o_if_rdata;
      if (ack) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack from %s expected none", (s == 0) ? "lsu" : "if");
        end else begin
          e = sb.pop_front();
          check("ack_owner_is_lsu", {31'b0, (s == 0)}, {31'b0, e.lsu});
          if (e.chk)
            check("ack_rdata", rd, e.data);
        end
      end
    end
  end

  logic [31:0] mem [256];
  int gnt_delay = 0;
  int rv_delay  = 0;

  initial begin : mem_model
    int          phase;
    int          cnt;
    logic        w;
    logic [7:0]  idx;
    logic [31:0] wd;
    logic [3:0]  bm;
    phase = 0; cnt = 0; w = 0; idx = '0; wd = '0; bm = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      if (!rst_n) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (o_mem_req) begin
          if (cnt == gnt_delay) begin
            i_mem_gnt = 1'b1;
            w = o_mem_wren; idx = o_mem_addr[9:2]; wd = o_mem_wdata; bm = o_mem_bmask;
            phase = 1; cnt = 0;
          end else cnt++;
        end
      end else begin
        if (cnt == rv_delay) begin
          i_mem_rvalid = 1'b1;
          if (w) begin
            for (int b = 0; b < 4; b++)
              if (bm[b]) mem[idx][b*8 +: 8] = wd[b*8 +: 8];
            i_mem_rdata = '0;
          end else
            i_mem_rdata = mem[idx];
          phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  task automatic do_if(input logic [31:0] addr, output int cyc, output int stall_lo);
    bit got;
    got = 0; cyc = 0; stall_lo = 0;
    i_if_addr = addr;
    i_if_req  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (!o_stall_if) stall_lo++;
      @(negedge clk);
      cyc++;
      if (o_if_ack) begin got = 1; break; end
    end
    if (got) check("if_stall_in_ack", {31'b0, o_stall_if}, 32'd0);
    else begin
      vectors++; miscompares++;
      $display("FAIL if_ack_timeout: got no ack in %0d cycles expected ack", cyc);
    end
    i_if_req = 1'b0;
  endtask

  task automatic do_lsu(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] bmask, output int cyc);
    bit got;
    got = 0; cyc = 0;
    i_lsu_wren = wren; i_lsu_addr = addr; i_lsu_wdata = wdata; i_lsu_bmask = bmask;
    i_lsu_req  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      if (o_lsu_ack) begin got = 1; break; end
    end
    if (got) check("lsu_stall_in_ack", {31'b0, o_stall_lsu}, 32'd0);
    else begin
      vectors++; miscompares++;
      $display("FAIL lsu_ack_timeout: got no ack in %0d cycles expected ack", cyc);
    end
    i_lsu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ic, lc, slo, reqc, bad, acks;
    rst_n = 1'b0; i_flush = 0; i_if_req = 0; i_if_addr = '0;
    i_lsu_req = 0; i_lsu_wren = 0; i_lsu_addr = '0; i_lsu_wdata = '0; i_lsu_bmask = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | (i << 2);
    mem[8'h40] = 32'h0000_0013;
    mem[8'h41] = 32'h0010_0093;

    repeat (2) @(negedge clk);
    check("rst_mem_req",   {31'b0, o_mem_req}, 32'd0);
    check("rst_mem_wren",  {31'b0, o_mem_wren}, 32'd0);
    check("rst_mem_addr",  o_mem_addr, 32'd0);
    check("rst_mem_bmask", {28'b0, o_mem_bmask}, 32'd0);
    check("rst_acks",      {30'b0, o_if_ack, o_lsu_ack}, 32'd0);
    check("rst_if_rdata",  o_if_rdata, 32'd0);
    check("rst_lsu_rdata", o_lsu_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // IF-only fetch at minimum latency
    push_exp(0, 1, 32'h0000_0013);
    fork
      do_if(32'h100, ic, slo);
      begin
        @(negedge clk);
        check("if_mem_req",   {31'b0, o_mem_req}, 32'd1);
        check("if_mem_addr",  o_mem_addr, 32'h100);
        check("if_mem_wren",  {31'b0, o_mem_wren}, 32'd0);
        check("if_mem_bmask", {28'b0, o_mem_bmask}, 32'hF);
      end
    join
    check("if_latency", ic, 32'd3);
    check("if_stall_held", slo, 32'd0);
    repeat (2) @(negedge clk);

    // Simultaneous IF + LSU load: LSU first
    push_exp(1, 1, 32'hA5A5_0300);
    push_exp(0, 1, 32'h0010_0093);
    fork
      do_lsu(1'b0, 32'h300, 32'h0, 4'h0, lc);
      do_if(32'h104, ic, slo);
    join
    check("tie_lsu_latency", lc, 32'd3);
    check("tie_if_latency", ic, 32'd7);
    check("tie_if_stall_throughout", slo, 32'd0);
    repeat (2) @(negedge clk);

    // Anti-starvation: IF forced in after the 4th LSU grant
    push_exp(1, 1, 32'hA5A5_0310);
    push_exp(1, 1, 32'hA5A5_0314);
    push_exp(1, 1, 32'hA5A5_0318);
    push_exp(1, 1, 32'hA5A5_031C);
    push_exp(0, 1, 32'hA5A5_0108);
    push_exp(1, 1, 32'hA5A5_0320);
    push_exp(1, 1, 32'hA5A5_0324);
    fork
      for (int k = 0; k < 6; k++) do_lsu(1'b0, 32'h310 + 32'(4 * k), 32'h0, 4'h0, lc);
      do_if(32'h108, ic, slo);
    join
    check("starve_if_latency", ic, 32'd19);
    repeat (2) @(negedge clk);

    // Store with delayed grant: request and fields held stable
    gnt_delay = 3;
    push_exp(1, 0, 32'h0);
    reqc = 0; bad = 0;
    fork
      do_lsu(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, lc);
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (o_lsu_ack) break;
        if (o_mem_req) begin
          reqc++;
          if (o_mem_wren !== 1'b1 || o_mem_addr !== 32'h200 ||
              o_mem_wdata !== 32'hDEAD_BEEF || o_mem_bmask !== 4'b0011) bad++;
        end
      end
    join
    check("store_req_cycles", reqc, 32'd4);
    check("store_fields_stable", bad, 32'd0);
    check("store_latency", lc, 32'd6);
    gnt_delay = 0;
    push_exp(1, 1, 32'hA5A5_BEEF);
    do_lsu(1'b0, 32'h200, 32'h0, 4'h0, lc);
    repeat (2) @(negedge clk);

    // Flush while the fetch is in WAIT
    rv_delay = 3;
    i_if_addr = 32'h10C; i_if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("flush_in_wait", {31'b0, o_mem_req}, 32'd0);
    i_flush = 1'b1;
    #1;
    check("stall_if_during_flush", {31'b0, o_stall_if}, 32'd0);
    @(negedge clk);
    i_flush = 1'b0; i_if_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_if_ack) acks++;
    end
    check("flush_no_if_ack", acks, 32'd0);
    check("flush_rdata_held", o_if_rdata, 32'hA5A5_0108);
    rv_delay = 0;
    push_exp(0, 1, 32'h0000_0013);
    do_if(32'h100, ic, slo);
    check("fetch_after_flush_latency", ic, 32'd3);
    repeat (2) @(negedge clk);

    // Flush in IDLE blocks the IF grant that cycle
    i_if_addr = 32'h104; i_if_req = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_grant", {31'b0, o_mem_req}, 32'd0);
    i_flush = 1'b0;
    push_exp(0, 1, 32'h0010_0093);
    do_if(32'h104, ic, slo);
    check("fetch_after_idle_flush_latency", ic, 32'd3);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a WAIT
    rv_delay = 3;
    i_if_addr = 32'h100; i_if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_req",   {31'b0, o_mem_req}, 32'd0);
    check("arst_mem_addr",  o_mem_addr, 32'd0);
    check("arst_if_rdata",  o_if_rdata, 32'd0);
    check("arst_lsu_rdata", o_lsu_rdata, 32'd0);
    check("arst_acks",      {30'b0, o_if_ack, o_lsu_ack}, 32'd0);
    i_if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_delay = 0;
    @(negedge clk);
    push_exp(0, 1, 32'h0000_0013);
    do_if(32'h100, ic, slo);
    check("fetch_after_reset_latency", ic, 32'd3);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
